// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory.
// Writes finish at the grant edge; reads return data two cycles after grant.
module mem_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] prio;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             issue;

    // First set request bit at or above the priority pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(prio) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Gated by rst_n so outputs drop to zero the moment reset asserts.
    assign issue = rst_n && (state == IDLE) && found;

    always_comb begin
        gnt       = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue) begin
            gnt       = ONE << win;
            mem_en    = 1'b1;
            mem_we    = req_we[win];
            mem_addr  = req_addr[win*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[win*DATA_W +: DATA_W];
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (issue && !req_we[win]) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio   <= '0;
            owner  <= '0;
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= '0;
            if (issue) begin
                prio  <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                owner <= win;
            end
            if (state == RD_WAIT) begin
                rdata  <= mem_rdata;
                rvalid <= ONE << owner;
            end
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a behavioural 1-cycle memory.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_mem_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    logic [DW-1:0]   mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_rr_arbiter #(
        .NUM_REQ(N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .busy     (busy),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory contents reload on reset; 0x20 preloaded with 0x3C.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem[i] <= (i == 'h20) ? 8'h3C : 8'h00;
            end
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req    = '0;
        req_we = '0;
        rst_n  = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b1111;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        cyc();
        cyc();
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        req = '0;
        cyc();
        rst_n = 1'b1;

        // single write then read by requester 0
        cyc();
        req            = 4'b0001;
        req_we         = 4'b0001;
        req_addr[7:0]  = 8'h10;
        req_wdata[7:0] = 8'hA5;
        #1;
        chk("w_gnt", 32'(gnt), 'b0001);
        chk("w_mem_en", 32'(mem_en), 1);
        chk("w_mem_we", 32'(mem_we), 1);
        chk("w_mem_addr", 32'(mem_addr), 'h10);
        chk("w_mem_wdata", 32'(mem_wdata), 'hA5);
        cyc();
        req_we = 4'b0000;
        #1;
        chk("r_gnt", 32'(gnt), 'b0001);
        chk("r_mem_we", 32'(mem_we), 0);
        cyc();
        req = '0;
        #1;
        chk("rw_busy", 32'(busy), 1);
        chk("rw_gnt", 32'(gnt), 0);
        chk("rw_mem_en", 32'(mem_en), 0);
        chk("rw_rvalid", 32'(rvalid), 0);
        cyc();
        #1;
        chk("r_rvalid", 32'(rvalid), 'b0001);
        chk("r_rdata", 32'(rdata), 'hA5);
        chk("r_busy", 32'(busy), 0);
        cyc();
        #1;
        chk("r_rvalid_clr", 32'(rvalid), 0);
        chk("r_rdata_hold", 32'(rdata), 'hA5);

        // four continuous writers from reset
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = 8'(i + 'h40);
        end
        req    = 4'b1111;
        req_we = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_gnt", 32'(gnt), 1 << (i % 4));
            chk("rr_addr", 32'(mem_addr), 'h40 + (i % 4));
            cyc();
        end

        // pointer wrap with req1/req3, then req0 inserted
        do_reset();
        req    = 4'b1010;
        req_we = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wrap_gnt", 32'(gnt), (i % 2 == 0) ? 'b0010 : 'b1000);
            cyc();
        end
        req = 4'b1011;
        #1;
        chk("ins_gnt0", 32'(gnt), 'b0001);
        cyc();
        #1;
        chk("ins_gnt1", 32'(gnt), 'b0010);
        cyc();

        // read by req2 overlapping a pending write by req0
        do_reset();
        req              = 4'b0100;
        req_we           = 4'b0000;
        req_addr[23:16]  = 8'h20;
        #1;
        chk("ov_gnt2", 32'(gnt), 'b0100);
        cyc();
        req            = 4'b0001;
        req_we         = 4'b0001;
        req_addr[7:0]  = 8'h30;
        req_wdata[7:0] = 8'h77;
        #1;
        chk("ov_busy", 32'(busy), 1);
        chk("ov_wait_gnt", 32'(gnt), 0);
        cyc();
        #1;
        chk("ov_gnt0", 32'(gnt), 'b0001);
        chk("ov_mem_we", 32'(mem_we), 1);
        chk("ov_rvalid", 32'(rvalid), 'b0100);
        chk("ov_rdata", 32'(rdata), 'h3C);
        cyc();

        // reset while in RD_WAIT (pointer is 1 here)
        req             = 4'b0010;
        req_we          = 4'b0000;
        req_addr[15:8]  = 8'h20;
        #1;
        chk("mr_gnt1", 32'(gnt), 'b0010);
        cyc();
        req = '0;
        #1;
        chk("mr_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_rdata", 32'(rdata), 0);
        chk("mr_rvalid", 32'(rvalid), 0);
        chk("mr_mem_en", 32'(mem_en), 0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("mr_rvalid_a", 32'(rvalid), 0);
        cyc();
        #1;
        chk("mr_rvalid_b", 32'(rvalid), 0);
        req    = 4'b1111;
        req_we = 4'b1111;
        #1;
        chk("mr_first_gnt", 32'(gnt), 'b0001);
        cyc();
        req = '0;
        cyc();

        // withdrawn request from requester 3 (pointer now 1)
        req    = 4'b1010;
        req_we = 4'b0010;
        #1;
        chk("wd_gnt1", 32'(gnt), 'b0010);
        cyc();
        req = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wd_gnt", 32'(gnt), 0);
            chk("wd_mem_en", 32'(mem_en), 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
